// File: rtl/fab_clken_pkg.sv
// Shared constants and the per-channel configuration record for the fabric
// clock-enable generator.
package fab_clken_pkg;

    localparam int DEF_NUM_CH      = 3;
    localparam int DEF_DIV_W       = 5;
    localparam int DEF_DLY_W       = 5;
    localparam int DEF_DIV         = 3;
    localparam int DEF_LOCK_CYCLES = 16;

    // Record fields are sized for the widest supported DIV_W/DLY_W.
    // Channels use only the low bits they need.
    localparam int CFG_FIELD_W = 16;

    typedef struct packed {
        logic [CFG_FIELD_W-1:0] div;
        logic [CFG_FIELD_W-1:0] dly;
        logic                   bypass;
    } chan_cfg_t;

    function automatic int ch_idx_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/fab_clken_chan.sv
// One clock-enable channel: divide counter, post-update phase hold and
// glitchless application of a staged configuration on its wrap edge.
module fab_clken_chan
    import fab_clken_pkg::*;
#(
    parameter int DIV_W       = DEF_DIV_W,
    parameter int DLY_W       = DEF_DLY_W,
    parameter int DEFAULT_DIV = DEF_DIV
) (
    input  logic      clk_i,
    input  logic      rst_ni,
    input  logic      pend_i,
    input  chan_cfg_t cfg_i,
    output logic      apply_o,
    output logic      clken_o
);

    logic [DIV_W-1:0] div_q, div_d;
    logic [DIV_W-1:0] cnt_q, cnt_d;
    logic [DLY_W-1:0] dly_q, dly_d;
    logic             byp_q, byp_d;
    logic             clken_q, clken_d;
    logic             hold;
    logic             wrap;
    logic             unused_cfg_bits;

    assign unused_cfg_bits = ^{cfg_i.div, cfg_i.dly};

    // Bypass counts as a wrap on every edge, so an update aimed at a
    // bypassed channel lands on the very next edge.
    always_comb begin
        hold    = (dly_q != '0);
        wrap    = byp_q || (!hold && (cnt_q == div_q));
        apply_o = pend_i && wrap;
        div_d   = div_q;
        cnt_d   = cnt_q;
        dly_d   = dly_q;
        byp_d   = byp_q;
        clken_d = 1'b0;
        if (apply_o) begin
            div_d   = cfg_i.div[DIV_W-1:0];
            byp_d   = cfg_i.bypass;
            dly_d   = cfg_i.bypass ? '0 : cfg_i.dly[DLY_W-1:0];
            cnt_d   = '0;
            clken_d = 1'b1;
        end else if (wrap) begin
            cnt_d   = '0;
            clken_d = 1'b1;
        end else if (hold) begin
            dly_d   = dly_q - 1'b1;
        end else begin
            cnt_d   = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            div_q   <= DIV_W'(DEFAULT_DIV);
            cnt_q   <= '0;
            dly_q   <= '0;
            byp_q   <= 1'b0;
            clken_q <= 1'b0;
        end else begin
            div_q   <= div_d;
            cnt_q   <= cnt_d;
            dly_q   <= dly_d;
            byp_q   <= byp_d;
            clken_q <= clken_d;
        end
    end

    assign clken_o = clken_q;

endmodule

// File: rtl/fab_clken_gen.sv
// Fabric clock-enable generator: configuration handshake with a single
// staging slot, per-channel enable generators and a settle/LOCK monitor.
module fab_clken_gen
    import fab_clken_pkg::*;
#(
    parameter int NUM_CH      = DEF_NUM_CH,
    parameter int DIV_W       = DEF_DIV_W,
    parameter int DLY_W       = DEF_DLY_W,
    parameter int DEFAULT_DIV = DEF_DIV,
    parameter int LOCK_CYCLES = DEF_LOCK_CYCLES
) (
    input  logic                        FAB_CLK,
    input  logic                        M2F_RESET_N,
    input  logic                        CFG_VALID,
    output logic                        CFG_READY,
    input  logic [ch_idx_w(NUM_CH)-1:0] CFG_CH,
    input  logic [DIV_W-1:0]            CFG_DIV,
    input  logic [DLY_W-1:0]            CFG_DLY,
    input  logic                        CFG_BYPASS,
    output logic [NUM_CH-1:0]           CLKEN,
    output logic                        LOCK
);

    localparam int CH_W = ch_idx_w(NUM_CH);
    localparam int ST_W = (LOCK_CYCLES < 1) ? 1 : $clog2(LOCK_CYCLES + 1);

    logic              slot_vld_q, slot_vld_d;
    logic [CH_W-1:0]   slot_ch_q;
    chan_cfg_t         slot_cfg_q;
    logic              ready_q;
    logic              lock_q, lock_d;
    logic [ST_W-1:0]   settle_q, settle_d;
    logic [NUM_CH-1:0] pend;
    logic [NUM_CH-1:0] apply;
    logic              accept;
    logic              slot_ch_ok;
    logic              any_apply;

    // An out-of-range target occupies the slot for one cycle, then is dropped.
    always_comb begin
        accept     = CFG_VALID && ready_q;
        slot_ch_ok = ({1'b0, slot_ch_q} < (CH_W + 1)'(NUM_CH));
        any_apply  = |apply;
        slot_vld_d = slot_vld_q;
        if (accept) begin
            slot_vld_d = 1'b1;
        end else if (slot_vld_q && (any_apply || !slot_ch_ok)) begin
            slot_vld_d = 1'b0;
        end
        settle_d = settle_q;
        if (any_apply) begin
            settle_d = '0;
        end else if (settle_q < ST_W'(LOCK_CYCLES)) begin
            settle_d = settle_q + 1'b1;
        end
        lock_d = (settle_d == ST_W'(LOCK_CYCLES)) && !(slot_vld_q && slot_ch_ok);
    end

    always_ff @(posedge FAB_CLK or negedge M2F_RESET_N) begin
        if (!M2F_RESET_N) begin
            slot_vld_q <= 1'b0;
            slot_ch_q  <= '0;
            slot_cfg_q <= '0;
            ready_q    <= 1'b0;
            settle_q   <= '0;
            lock_q     <= 1'b0;
        end else begin
            slot_vld_q <= slot_vld_d;
            if (accept) begin
                slot_ch_q         <= CFG_CH;
                slot_cfg_q.div    <= CFG_FIELD_W'(CFG_DIV);
                slot_cfg_q.dly    <= CFG_FIELD_W'(CFG_DLY);
                slot_cfg_q.bypass <= CFG_BYPASS;
            end
            ready_q  <= !slot_vld_d;
            settle_q <= settle_d;
            lock_q   <= lock_d;
        end
    end

    for (genvar i = 0; i < NUM_CH; i++) begin : g_chan
        assign pend[i] = slot_vld_q && (slot_ch_q == CH_W'(i));

        fab_clken_chan #(
            .DIV_W       (DIV_W),
            .DLY_W       (DLY_W),
            .DEFAULT_DIV (DEFAULT_DIV)
        ) u_chan (
            .clk_i   (FAB_CLK),
            .rst_ni  (M2F_RESET_N),
            .pend_i  (pend[i]),
            .cfg_i   (slot_cfg_q),
            .apply_o (apply[i]),
            .clken_o (CLKEN[i])
        );
    end

    assign CFG_READY = ready_q;
    assign LOCK      = lock_q;

endmodule
